// File: rtl/imem_uart_loader.sv
// UART boot loader: receives a length-prefixed little-endian image over 8N1 serial
// and writes it word by word into imem, holding the core in reset until it is complete.
module imem_uart_loader #(
  parameter int CLKS_PER_BIT = 434,
  parameter int ADDR_WIDTH   = 16,
  parameter int MAX_WORDS    = 16384
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  uart_rx_i,
  output logic                  imem_we_out,
  output logic [ADDR_WIDTH-1:0] imem_wr_addr_out,
  output logic [31:0]           imem_wr_data_out,
  output logic                  cpu_rst_out,
  output logic                  load_busy,
  output logic                  load_done,
  output logic                  load_err
);

  localparam int HALF  = CLKS_PER_BIT / 2;
  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int IDX_W = $clog2(MAX_WORDS + 1);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  typedef enum logic [1:0] {L_LEN, L_DATA, L_DONE, L_ERR} ld_state_t;

  rx_state_t        rx_state;
  ld_state_t        ld_state;
  logic [1:0]       rx_sync;
  logic             rx_s;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shreg;
  logic             byte_valid;
  logic             frame_err;

  logic [1:0]       byte_cnt;
  logic [1:0]       lane;
  logic [23:0]      len_lo;
  logic [23:0]      data_buf;
  logic [31:0]      len_full;
  logic [IDX_W-1:0] word_idx;
  logic [IDX_W-1:0] last_idx;
  logic             last_pend;

  assign rx_s     = rx_sync[1];
  assign len_full = {shreg, len_lo};

  // Receiver: byte_valid / frame_err are one-cycle pulses, shreg holds the byte.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_sync    <= 2'b11;
      rx_state   <= RX_IDLE;
      cnt        <= '0;
      bit_idx    <= '0;
      shreg      <= '0;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      rx_sync    <= {rx_sync[0], uart_rx_i};
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
      case (rx_state)
        RX_IDLE: begin
          cnt <= '0;
          if (!rx_s) rx_state <= RX_START;
        end
        RX_START: begin
          if (cnt == CNT_W'(HALF - 1)) begin
            cnt      <= '0;
            bit_idx  <= '0;
            rx_state <= rx_s ? RX_IDLE : RX_DATA;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RX_DATA: begin
          if (cnt == CNT_W'(CLKS_PER_BIT - 1)) begin
            cnt     <= '0;
            shreg   <= {rx_s, shreg[7:1]};
            bit_idx <= bit_idx + 1'b1;
            if (bit_idx == 3'd7) rx_state <= RX_STOP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RX_STOP: begin
          if (cnt == CNT_W'(CLKS_PER_BIT - 1)) begin
            cnt <= '0;
            if (rx_s) byte_valid <= 1'b1;
            else      frame_err  <= 1'b1;
            rx_state <= RX_IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: rx_state <= RX_IDLE;
      endcase
    end
  end

  // Loader: bytes shift in from the top so the buffers end up little-endian.
  always_ff @(posedge clk) begin
    if (rst) begin
      ld_state         <= L_LEN;
      byte_cnt         <= '0;
      lane             <= '0;
      len_lo           <= '0;
      data_buf         <= '0;
      word_idx         <= '0;
      last_idx         <= '0;
      last_pend        <= 1'b0;
      imem_we_out      <= 1'b0;
      imem_wr_addr_out <= '0;
      imem_wr_data_out <= '0;
      cpu_rst_out      <= 1'b1;
      load_busy        <= 1'b0;
      load_done        <= 1'b0;
      load_err         <= 1'b0;
    end else begin
      imem_we_out <= 1'b0;
      case (ld_state)
        L_LEN: begin
          if (frame_err) begin
            ld_state  <= L_ERR;
            load_err  <= 1'b1;
            load_busy <= 1'b0;
          end else if (byte_valid) begin
            load_busy <= 1'b1;
            byte_cnt  <= byte_cnt + 1'b1;
            len_lo    <= {shreg, len_lo[23:8]};
            if (byte_cnt == 2'd3) begin
              if (len_full == 32'd0) begin
                ld_state    <= L_DONE;
                load_done   <= 1'b1;
                load_busy   <= 1'b0;
                cpu_rst_out <= 1'b0;
              end else if (len_full > 32'(MAX_WORDS)) begin
                ld_state  <= L_ERR;
                load_err  <= 1'b1;
                load_busy <= 1'b0;
              end else begin
                ld_state <= L_DATA;
                word_idx <= '0;
                lane     <= '0;
                last_idx <= IDX_W'(len_full - 32'd1);
              end
            end
          end
        end
        L_DATA: begin
          // last_pend is high exactly while the final strobe is on the port.
          if (last_pend) begin
            last_pend   <= 1'b0;
            ld_state    <= L_DONE;
            load_done   <= 1'b1;
            load_busy   <= 1'b0;
            cpu_rst_out <= 1'b0;
          end else if (frame_err) begin
            ld_state  <= L_ERR;
            load_err  <= 1'b1;
            load_busy <= 1'b0;
          end else if (byte_valid) begin
            lane <= lane + 1'b1;
            if (lane == 2'd3) begin
              imem_we_out      <= 1'b1;
              imem_wr_addr_out <= ADDR_WIDTH'({word_idx, 2'b00});
              imem_wr_data_out <= {shreg, data_buf};
              word_idx         <= word_idx + 1'b1;
              last_pend        <= (word_idx == last_idx);
            end else begin
              data_buf <= {shreg, data_buf[23:8]};
            end
          end
        end
        L_DONE: ld_state <= L_DONE;
        L_ERR:  ld_state <= L_ERR;
        default: ld_state <= L_ERR;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_uart_loader.sv
// Directed bench for imem_uart_loader: serial byte streams in, imem strobes and status out.
module tb_imem_uart_loader;

  localparam int CPB = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        uart_rx_i = 1'b1;
  logic        imem_we_out;
  logic [15:0] imem_wr_addr_out;
  logic [31:0] imem_wr_data_out;
  logic        cpu_rst_out;
  logic        load_busy;
  logic        load_done;
  logic        load_err;

  imem_uart_loader #(.CLKS_PER_BIT(CPB), .ADDR_WIDTH(16), .MAX_WORDS(16384)) dut (
    .clk              (clk),
    .rst              (rst),
    .uart_rx_i        (uart_rx_i),
    .imem_we_out      (imem_we_out),
    .imem_wr_addr_out (imem_wr_addr_out),
    .imem_wr_data_out (imem_wr_data_out),
    .cpu_rst_out      (cpu_rst_out),
    .load_busy        (load_busy),
    .load_done        (load_done),
    .load_err         (load_err)
  );

  // clock / reset
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc++;

  // strobe capture, sampled on the falling edge
  logic [15:0] addr_q[$];
  logic [31:0] data_q[$];
  int unsigned we_cyc = 0;
  int unsigned done_cyc = 0;
  logic        done_prev = 1'b0;

  always @(negedge clk) begin
    if (imem_we_out === 1'b1) begin
      addr_q.push_back(imem_wr_addr_out);
      data_q.push_back(imem_wr_data_out);
      we_cyc = cyc;
    end
    if (load_done === 1'b1 && !done_prev) done_cyc = cyc;
    done_prev = load_done;
  end

  int total = 0;
  int bad   = 0;
  int base  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %08h want %08h", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    uart_rx_i = 1'b1;
    rst = 1'b1;
    tick(3);
    rst = 1'b0;
  endtask

  task automatic send_bit(input logic v);
    uart_rx_i = v;
    tick(CPB);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit(stop_bit);
    uart_rx_i = 1'b1;
  endtask

  // bytes go out lowest first, back to back
  task automatic send_stream(input logic [95:0] s, input int n);
    for (int i = 0; i < n; i++) send_byte(s[8*i +: 8], 1'b1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    // 1: reset state, idle line
    @(posedge clk); #1;
    do_reset();
    check("rst_we",    {31'd0, imem_we_out}, 32'd0);
    check("rst_addr",  {16'd0, imem_wr_addr_out}, 32'd0);
    check("rst_data",  imem_wr_data_out, 32'd0);
    check("rst_cpu",   {31'd0, cpu_rst_out}, 32'd1);
    check("rst_busy",  {31'd0, load_busy}, 32'd0);
    check("rst_done",  {31'd0, load_done}, 32'd0);
    check("rst_err",   {31'd0, load_err}, 32'd0);
    base = addr_q.size();
    tick(200);
    check("idle_strobes", 32'(addr_q.size() - base), 32'd0);
    check("idle_cpu",     {31'd0, cpu_rst_out}, 32'd1);

    // 2: two-word load
    do_reset();
    base = addr_q.size();
    send_byte(8'h02, 1'b1);
    tick(10);
    check("t2_busy_mid", {31'd0, load_busy}, 32'd1);
    send_stream(96'h0000006F_00100013_000000, 11);
    tick(20);
    check("t2_count", 32'(addr_q.size() - base), 32'd2);
    if (addr_q.size() - base >= 2) begin
      check("t2_addr0", {16'd0, addr_q[base]},   32'h0000_0000);
      check("t2_data0", data_q[base],            32'h0010_0013);
      check("t2_addr1", {16'd0, addr_q[base+1]}, 32'h0000_0004);
      check("t2_data1", data_q[base+1],          32'h0000_006F);
    end
    check("t2_done",      {31'd0, load_done}, 32'd1);
    check("t2_cpu",       {31'd0, cpu_rst_out}, 32'd0);
    check("t2_busy",      {31'd0, load_busy}, 32'd0);
    check("t2_done_lat",  done_cyc, we_cyc + 1);
    check("t2_hold_addr", {16'd0, imem_wr_addr_out}, 32'h0000_0004);
    check("t2_hold_data", imem_wr_data_out, 32'h0000_006F);
    // bytes after completion are ignored
    send_stream(96'hAABBCCDD_00000001, 8);
    tick(20);
    check("t2_after_count", 32'(addr_q.size() - base), 32'd2);

    // 3: empty image
    do_reset();
    base = addr_q.size();
    send_stream(96'h00000000, 4);
    tick(20);
    check("t3_done",  {31'd0, load_done}, 32'd1);
    check("t3_cpu",   {31'd0, cpu_rst_out}, 32'd0);
    check("t3_busy",  {31'd0, load_busy}, 32'd0);
    check("t3_count", 32'(addr_q.size() - base), 32'd0);

    // 4: framing error on the third length byte
    do_reset();
    base = addr_q.size();
    send_byte(8'h01, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h00, 1'b0);
    tick(60);
    check("t4_err",  {31'd0, load_err}, 32'd1);
    check("t4_cpu",  {31'd0, cpu_rst_out}, 32'd1);
    check("t4_done", {31'd0, load_done}, 32'd0);
    check("t4_busy", {31'd0, load_busy}, 32'd0);
    send_stream(96'h44332211_00000001, 8);
    tick(20);
    check("t4_count",    32'(addr_q.size() - base), 32'd0);
    check("t4_err_hold", {31'd0, load_err}, 32'd1);

    // 5: one-cycle glitch, then a valid one-word image
    do_reset();
    base = addr_q.size();
    uart_rx_i = 1'b0;
    tick(1);
    uart_rx_i = 1'b1;
    tick(20);
    check("t5_glitch_busy", {31'd0, load_busy}, 32'd0);
    send_stream(96'h12345678_00000001, 8);
    tick(20);
    check("t5_count", 32'(addr_q.size() - base), 32'd1);
    if (addr_q.size() - base >= 1) begin
      check("t5_addr", {16'd0, addr_q[base]}, 32'h0000_0000);
      check("t5_data", data_q[base], 32'h1234_5678);
    end
    check("t5_done", {31'd0, load_done}, 32'd1);

    // 6a: reset in the middle of a word, then reload
    do_reset();
    base = addr_q.size();
    send_stream(96'hBBAA_00000001, 6);
    tick(20);
    check("t6_busy_mid", {31'd0, load_busy}, 32'd1);
    do_reset();
    check("t6_busy_rst", {31'd0, load_busy}, 32'd0);
    check("t6_cpu_rst",  {31'd0, cpu_rst_out}, 32'd1);
    send_stream(96'hDEADBEEF_00000001, 8);
    tick(20);
    check("t6_count", 32'(addr_q.size() - base), 32'd1);
    if (addr_q.size() - base >= 1) begin
      check("t6_addr", {16'd0, addr_q[base]}, 32'h0000_0000);
      check("t6_data", data_q[base], 32'hDEAD_BEEF);
    end
    check("t6_done", {31'd0, load_done}, 32'd1);

    // 6b: length one above the limit
    do_reset();
    base = addr_q.size();
    send_stream(96'h00004001, 4);
    tick(20);
    check("t6b_err",   {31'd0, load_err}, 32'd1);
    check("t6b_busy",  {31'd0, load_busy}, 32'd0);
    check("t6b_cpu",   {31'd0, cpu_rst_out}, 32'd1);
    check("t6b_count", 32'(addr_q.size() - base), 32'd0);

    // length exactly at the limit is accepted
    do_reset();
    send_stream(96'h00004000, 4);
    tick(20);
    check("max_err",  {31'd0, load_err}, 32'd0);
    check("max_busy", {31'd0, load_busy}, 32'd1);
    check("max_done", {31'd0, load_done}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/imem_uart_loader.md
Name: imem_uart_loader

Overview:
- UART boot loader on the write side of the instruction-memory port; the core only ever reads that port.
- Deserialises a byte stream on a dedicated RX pin and packs it into 32-bit little-endian words.
- Writes the words sequentially into imem starting at byte address 0.
- Holds the core in reset until the image is completely written.
- Sits at FPGA top level beside cpu_top and the imem BRAM.

Parameters:
CLKS_PER_BIT, 434, clock cycles per UART bit (50 MHz / 115200 baud); must be >= 4
ADDR_WIDTH, 16, width of the imem byte address
MAX_WORDS, 16384, largest accepted image length in words

Ports:
clk  input  1  system clock
rst  input  1  synchronous, active-high reset
uart_rx_i  input  1  serial input, idles high, 8N1, LSB first
imem_we_out  output  1  one-cycle imem write strobe
imem_wr_addr_out  output  ADDR_WIDTH  word-aligned byte address of the write
imem_wr_data_out  output  32  write data
cpu_rst_out  output  1  reset to the core, active-high
load_busy  output  1  image transfer in progress
load_done  output  1  image completely written (sticky)
load_err  output  1  protocol error (sticky)

Behaviour:
- Single clock domain. Reset is synchronous and active-high: clk and rst are sampled only on the rising clk edge.
- Reset values: imem_we_out=0, imem_wr_addr_out=0, imem_wr_data_out=0, cpu_rst_out=1, load_busy=0, load_done=0, load_err=0. All counters, the byte-lane register and both FSMs return to idle / L_LEN.
- uart_rx_i passes through a 2-flop synchroniser before any use. That gives 2 cycles of input latency.
- RX FSM states:
  - IDLE: wait for the synchronised line to read 0.
  - START: count CLKS_PER_BIT/2 cycles (integer division), then resample. If the line is 1, treat it as a glitch and return to IDLE with no byte. If 0, go to DATA.
  - DATA: sample 8 bits, each CLKS_PER_BIT cycles after the previous sample, LSB first.
  - STOP: sample after CLKS_PER_BIT cycles. A 1 produces a one-cycle internal byte_valid with the data. A 0 is a framing error: assert load_err and stop accepting bytes.
  - After STOP, return to IDLE.
- Loader FSM states: L_LEN, L_DATA, L_DONE, L_ERR.
- L_LEN:
  - Collect 4 bytes, little-endian, into len.
  - load_busy goes to 1 on the first byte_valid.
  - On the 4th byte: if len==0, go to L_DONE. If len>MAX_WORDS, go to L_ERR. Otherwise go to L_DATA with word_idx=0 and lane=0.
- L_DATA:
  - Byte lane k fills data bits [8k+7:8k].
  - On the byte_valid of lane 3, the next cycle drives imem_we_out=1, imem_wr_addr_out=word_idx*4 and imem_wr_data_out={b3,b2,b1,b0}.
  - In that same cycle word_idx increments.
  - The write of word len-1 moves the FSM to L_DONE one cycle after the strobe.
  - imem_wr_addr_out and imem_wr_data_out hold their last values between strobes.
  - Address arithmetic truncates to ADDR_WIDTH.
- L_DONE: load_done=1, load_busy=0, cpu_rst_out=0, all in the same cycle. Further bytes are ignored until rst.
- L_ERR: load_err=1, load_busy=0, cpu_rst_out stays 1, no further writes. Exit only by rst.
- Reset mid-transfer: partial word and count are discarded and the loader re-arms at L_LEN. Words already written are not rolled back.
- No flow control. Back-to-back bytes (stop bit followed immediately by the next start bit) must be accepted. A write strobe never coincides with the sampling of the next byte's start bit.

Test Plan:
All scenarios use CLKS_PER_BIT=4 unless stated.
1. Reset check: hold rst for 3 cycles, then release with the line idle high -> all outputs at reset values and no strobe for 200 cycles.
2. Two-word load: send bytes 02 00 00 00 13 00 10 00 6F 00 00 00 ->
   - strobe 1: addr 0x0000, data 0x00100013
   - strobe 2: addr 0x0004, data 0x0000006F
   - load_done=1 and cpu_rst_out=0 one cycle after strobe 2
   - exactly 2 strobes in total
3. Empty image: send 00 00 00 00 -> load_done=1 and no strobe.
4. Framing error: in 01 00 00 00, send the 3rd byte with stop bit 0 -> load_err=1, cpu_rst_out=1, load_done=0. A subsequent valid stream produces no strobes.
5. Glitch rejection: pull rx low for 1 cycle, then idle -> no byte accepted. A following 01 00 00 00 78 56 34 12 writes 0x12345678 at addr 0.
6. Reset mid-load and oversize length:
   - Assert rst after 6 bytes, then send 01 00 00 00 EF BE AD DE -> a single strobe, addr 0, data 0xDEADBEEF.
   - Separately, length bytes 01 40 00 00 (16385 words) -> load_err=1 and no strobe.
